// File: rtl/if_stage_if.sv
// Fetch-side memory bus of if_stage: request/accept handshake plus in-order responses.
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [INST_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ready_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ready_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: credit-limited in-order fetch into a small {pc, inst} buffer
// feeding decode; a flush redirects the PC and discards every response still in flight.
module if_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  if_stage_if.master        mem,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o
);
  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [INST_W-1:0] inst_mem [FIFO_DEPTH];

  logic empty, full, req, accept, rsp, drop, push, pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Credit rule on registered counts only, so mem_req_o never depends on an input.
  assign req    = (state == FETCH) && ((outstanding + count) < DEPTH_C);
  assign accept = req && mem.mem_ready_i;
  assign rsp    = mem.mem_rvalid_i && (outstanding != '0);
  assign drop   = rsp && (discard != '0);
  assign push   = rsp && (discard == '0) && !flush_i;
  assign pop    = !empty && !stall_i && !flush_i;

  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(rsp);

  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o = fetch_pc;

  assign inst_valid_o = !empty;
  assign pc_o         = empty ? '0 : pc_mem[rd_ptr];
  assign inst_o       = empty ? '0 : inst_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= mem.mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush_i) begin
        // Everything still owed by memory after this edge belongs to the old path.
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        discard  <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        state    <= (outstanding_nxt != '0) ? DRAIN : FETCH;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (drop)   discard  <= discard - CNT_W'(1);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(4);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        case (state)
          BOOT:    state <= FETCH;
          DRAIN:   if (discard == '0) state <= FETCH;
          default: state <= state;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !pop && full));
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst)
                                      !(mem.mem_rvalid_i && (outstanding == '0)));
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scripted start-up/stall table, directed flush/wrap/reset sequences,
// then random traffic checked against a queue-based model of the fetch stream.
`timescale 1ns/1ps
module tb_if_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_stage_if #(.ADDR_W(32), .INST_W(32)) mem_bus ();

  if_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .mem           (mem_bus),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expPc;
    int          due;
    int          epoch;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    bit          stall;
    bit          expReq;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expPc;
  } vec_t;

  memReq_t     memQ[$];
  entry_t      modelQ[$];
  vec_t        vecs[15];
  int          cycle, epoch, latMin, latMax, delivered;
  int          checks = 0;
  int          errors = 0;
  bit          scramble;
  logic [31:0] expFetch;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return scramble ? (a ^ 32'hC3A5_5A3C) : a;
  endfunction

  function automatic int staleCount();
    int n = 0;
    foreach (memQ[i]) if (memQ[i].epoch != epoch) n++;
    return n;
  endfunction

  function automatic bit respDue();
    return (memQ.size() > 0) && (memQ[0].due <= cycle);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
    end
  endtask

  task automatic resetModel();
    memQ.delete();
    modelQ.delete();
    cycle    = 0;
    epoch    = 0;
    expFetch = 32'h0;
  endtask

  task automatic checkOutput();
    bit hv;
    hv = modelQ.size() > 0;
    check("inst_valid", inst_valid_o, hv);
    check("pc", pc_o, hv ? modelQ[0].pc : 32'h0);
    check("inst", inst_o, hv ? modelQ[0].inst : 32'h0);
    check("mem_addr", mem_bus.mem_addr_o, expFetch);
    if (mem_bus.mem_req_o) begin
      check("credit", (memQ.size() + modelQ.size()) < DEPTH, 1);
      check("no_req_while_stale", staleCount() == 0, 1);
    end
  endtask

  // Drives one cycle of inputs and advances the model to the state after the coming edge.
  task automatic applyStimulus(input bit s, input bit f, input logic [31:0] rpc, input bit rdy);
    bit      accept, respond, keep, pop;
    memReq_t ent, r;
    stall_i               = s;
    flush_i               = f;
    redirect_pc_i         = rpc;
    mem_bus.mem_ready_i   = rdy;
    accept                = mem_bus.mem_req_o && rdy;
    respond               = respDue();
    mem_bus.mem_rvalid_i  = respond;
    mem_bus.mem_rdata_i   = respond ? dataOf(memQ[0].addr) : 32'h0;
    keep = 1'b0;
    if (respond) begin
      ent  = memQ.pop_front();
      keep = (ent.epoch == epoch) && !f;
    end
    pop = (modelQ.size() > 0) && !s && !f;
    if (f) modelQ.delete();
    else begin
      if (pop) begin
        void'(modelQ.pop_front());
        delivered++;
      end
      if (keep) modelQ.push_back('{pc: ent.expPc, inst: dataOf(ent.expPc)});
    end
    if (accept) begin
      r.addr  = mem_bus.mem_addr_o;
      r.expPc = expFetch;
      r.due   = cycle + $urandom_range(latMax, latMin);
      r.epoch = epoch;
      memQ.push_back(r);
    end
    if (f) begin
      expFetch = rpc;
      epoch++;
    end else if (accept) expFetch = expFetch + 32'd4;
    cycle++;
  endtask

  task automatic step();
    applyStimulus(0, 0, 32'h0, 1);
    @(negedge clk);
  endtask

  task automatic waitValid(input string name, input logic [31:0] expPc, input int budget);
    bit found;
    found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      checkOutput();
      if (inst_valid_o) begin
        check(name, pc_o, expPc);
        found = 1;
      end else step();
    end
    if (!found) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          found;
    logic [31:0] holdAddr;

    // stall, expReq, expAddr, expValid, expPc (1-cycle memory, data = address)
    vecs[0]  = '{0, 0, 32'd0,  0, 32'd0};
    vecs[1]  = '{0, 1, 32'd0,  0, 32'd0};
    vecs[2]  = '{0, 1, 32'd4,  0, 32'd0};
    vecs[3]  = '{0, 0, 32'd8,  1, 32'd0};
    vecs[4]  = '{0, 1, 32'd8,  1, 32'd4};
    vecs[5]  = '{0, 1, 32'd12, 0, 32'd0};
    vecs[6]  = '{1, 0, 32'd16, 1, 32'd8};
    vecs[7]  = '{1, 0, 32'd16, 1, 32'd8};
    vecs[8]  = '{1, 0, 32'd16, 1, 32'd8};
    vecs[9]  = '{1, 0, 32'd16, 1, 32'd8};
    vecs[10] = '{1, 0, 32'd16, 1, 32'd8};
    vecs[11] = '{0, 0, 32'd16, 1, 32'd8};
    vecs[12] = '{0, 1, 32'd16, 1, 32'd12};
    vecs[13] = '{0, 1, 32'd20, 0, 32'd0};
    vecs[14] = '{0, 0, 32'd24, 1, 32'd16};

    mem_bus.mem_ready_i  = 1'b0;
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_rdata_i  = '0;
    scramble  = 0;
    latMin    = 1;
    latMax    = 1;
    delivered = 0;
    resetModel();

    @(negedge clk);
    @(negedge clk);
    check("rst_req", mem_bus.mem_req_o, 0);
    check("rst_addr", mem_bus.mem_addr_o, 32'h0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      check("tbl_req", mem_bus.mem_req_o, vecs[i].expReq);
      check("tbl_addr", mem_bus.mem_addr_o, vecs[i].expAddr);
      check("tbl_valid", inst_valid_o, vecs[i].expValid);
      check("tbl_pc", pc_o, vecs[i].expPc);
      check("tbl_inst", inst_o, vecs[i].expPc);
      applyStimulus(vecs[i].stall, 0, 32'h0, 1);
      @(negedge clk);
    end

    // Memory refuses requests: request and address must hold.
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      checkOutput();
      if (mem_bus.mem_req_o) found = 1;
      else step();
    end
    if (!found) check("ready_low_req_timeout", 0, 1);
    holdAddr = mem_bus.mem_addr_o;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) checkOutput();
      check("hold_req", mem_bus.mem_req_o, 1);
      check("hold_addr", mem_bus.mem_addr_o, holdAddr);
      applyStimulus(0, 0, 32'h0, 0);
      @(negedge clk);
    end
    checkOutput();
    check("hold_after_req", mem_bus.mem_req_o, 1);
    check("hold_after_addr", mem_bus.mem_addr_o, holdAddr);

    // Flush with two requests in flight on a 3-cycle memory.
    latMin = 3;
    latMax = 3;
    found  = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (memQ.size() == DEPTH) found = 1;
      else begin
        step();
        checkOutput();
      end
    end
    if (!found) check("two_in_flight_timeout", 0, 1);
    applyStimulus(0, 1, 32'h100, 0);
    @(negedge clk);
    waitValid("flush_first_pc", 32'h100, 60);

    // Flush coinciding with a response and an accepted request.
    latMin = 1;
    latMax = 1;
    found  = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mem_bus.mem_req_o && respDue()) found = 1;
      else begin
        step();
        checkOutput();
      end
    end
    if (!found) check("coincide_timeout", 0, 1);
    else begin
      applyStimulus(0, 1, 32'h200, 1);
      @(negedge clk);
      waitValid("flush_coincide_pc", 32'h200, 40);
    end

    // Address wrap at the top of the address space.
    step();
    checkOutput();
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1);
    @(negedge clk);
    waitValid("wrap_pc0", 32'hFFFF_FFF8, 40);
    step();
    waitValid("wrap_pc1", 32'hFFFF_FFFC, 40);
    step();
    waitValid("wrap_pc2", 32'h0, 40);

    // Asynchronous reset between clock edges.
    applyStimulus(1, 0, 32'h0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_req", mem_bus.mem_req_o, 0);
    check("async_addr", mem_bus.mem_addr_o, 32'h0);
    check("async_valid", inst_valid_o, 0);
    check("async_pc", pc_o, 32'h0);
    check("async_inst", inst_o, 32'h0);
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_ready_i  = 1'b0;
    stall_i              = 1'b0;
    resetModel();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic: stalls, flushes, back-pressure and variable latency.
    scramble  = 1;
    latMin    = 1;
    latMax    = 4;
    delivered = 0;
    for (int k = 0; k < 3000; k++) begin
      checkOutput();
      applyStimulus($urandom_range(99) < 30, $urandom_range(99) < 3,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(99) < 70);
      @(negedge clk);
    end
    check("random_delivered", delivered > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
